// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the display encoder and the readback decoder.
// Segment bit order is 6..0. DIGI_X is the blank (all segments off) pattern.
package seg7_pkg;

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned VALUE_W = 7;

    localparam logic [SEG_W-1:0] DIGI_0 = 7'b0111111;
    localparam logic [SEG_W-1:0] DIGI_1 = 7'b0011000;
    localparam logic [SEG_W-1:0] DIGI_2 = 7'b1110110;
    localparam logic [SEG_W-1:0] DIGI_3 = 7'b1111100;
    localparam logic [SEG_W-1:0] DIGI_4 = 7'b1011001;
    localparam logic [SEG_W-1:0] DIGI_5 = 7'b1101101;
    localparam logic [SEG_W-1:0] DIGI_6 = 7'b1101111;
    localparam logic [SEG_W-1:0] DIGI_7 = 7'b0111000;
    localparam logic [SEG_W-1:0] DIGI_8 = 7'b1111111;
    localparam logic [SEG_W-1:0] DIGI_9 = 7'b1111101;
    localparam logic [SEG_W-1:0] DIGI_X = 7'b0000000;

    // Result of decoding one segment pattern.
    typedef struct packed {
        logic [DIGIT_W-1:0] digit;
        logic               blank;
        logic               bad;
    } digit_dec_t;

    // tens*10 + ones at 7 bits, so values up to 99 survive for the range check.
    function automatic logic [VALUE_W-1:0] seg7_value(input logic [DIGIT_W-1:0] tens,
                                                      input logic [DIGIT_W-1:0] ones);
        return (VALUE_W'(tens) << 3) + (VALUE_W'(tens) << 1) + VALUE_W'(ones);
    endfunction

endpackage

// File: rtl/seg7_to_hex_6bit_if.sv
// Sample/result bundle of seg7_to_hex_6bit.
//   master : drives in_valid, digi_0, digi_1; observes hex, hex_valid, out_valid, err
//   slave  : the decoder side
interface seg7_to_hex_6bit_if;
    logic       in_valid;
    logic [6:0] digi_0;
    logic [6:0] digi_1;
    logic [5:0] hex;
    logic       hex_valid;
    logic       out_valid;
    logic       err;

    modport master (
        output in_valid, digi_0, digi_1,
        input  hex, hex_valid, out_valid, err
    );

    modport slave (
        input  in_valid, digi_0, digi_1,
        output hex, hex_valid, out_valid, err
    );
endinterface

// File: rtl/seg7_digit_decode.sv
// Combinational decode of one 7-segment pattern.
//   i_pattern : segment pattern, bit 6..0
//   o_dec_c   : {digit, blank, bad}; digit is 0 for blank and illegal patterns
module seg7_digit_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] i_pattern,
    output digit_dec_t       o_dec_c
);

    always_comb begin
        o_dec_c = '0;
        case (i_pattern)
            DIGI_0:  o_dec_c.digit = 4'd0;
            DIGI_1:  o_dec_c.digit = 4'd1;
            DIGI_2:  o_dec_c.digit = 4'd2;
            DIGI_3:  o_dec_c.digit = 4'd3;
            DIGI_4:  o_dec_c.digit = 4'd4;
            DIGI_5:  o_dec_c.digit = 4'd5;
            DIGI_6:  o_dec_c.digit = 4'd6;
            DIGI_7:  o_dec_c.digit = 4'd7;
            DIGI_8:  o_dec_c.digit = 4'd8;
            DIGI_9:  o_dec_c.digit = 4'd9;
            DIGI_X:  o_dec_c.blank = 1'b1;
            default: o_dec_c.bad   = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_to_hex_6bit.sv
// Decodes a tens/ones 7-segment pair back to a 6-bit value with a stability filter:
// a pair commits only after STABLE_CNT consecutive identical valid samples.
//   clock, rst_n : clock, asynchronous active-low reset
//   io_bus       : in_valid/digi_0/digi_1 in; hex, hex_valid, out_valid (pulse), err (pulse) out
module seg7_to_hex_6bit
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic                clock,
    input  logic                rst_n,
    seg7_to_hex_6bit_if.slave   io_bus
);

    localparam int unsigned          CNT_W   = 8;
    localparam int unsigned          PAIR_W  = 2 * SEG_W;
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(STABLE_CNT);
    localparam logic [VALUE_W-1:0]   VAL_MAX = VALUE_W'(63);

    digit_dec_t w_dec0;
    digit_dec_t w_dec1;

    logic                r_s1_valid;
    logic [DIGIT_W-1:0]  r_s1_tens;
    logic [DIGIT_W-1:0]  r_s1_ones;
    logic                r_s1_illegal;
    logic [PAIR_W-1:0]   r_s1_pair;

    logic [PAIR_W-1:0]   r_held_pair;
    logic                r_held_valid;
    logic [CNT_W-1:0]    r_cnt;

    logic [5:0]          r_hex;
    logic                r_hex_valid;
    logic                r_out_valid;
    logic                r_err;

    logic                w_match;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_commit;
    logic [VALUE_W-1:0]  w_value;
    logic                w_reject;

    seg7_digit_decode u_dec0 (.i_pattern(io_bus.digi_0), .o_dec_c(w_dec0));
    seg7_digit_decode u_dec1 (.i_pattern(io_bus.digi_1), .o_dec_c(w_dec1));

    // Stage 1: register decoded digits, the combined illegal flag and the raw pair.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_tens    <= '0;
            r_s1_ones    <= '0;
            r_s1_illegal <= 1'b0;
            r_s1_pair    <= '0;
        end else begin
            r_s1_valid <= io_bus.in_valid;
            if (io_bus.in_valid) begin
                // Blank tens is leading-zero suppression; blank ones is illegal.
                r_s1_tens    <= w_dec1.blank ? '0 : w_dec1.digit;
                r_s1_ones    <= w_dec0.digit;
                r_s1_illegal <= w_dec0.bad | w_dec1.bad | w_dec0.blank;
                r_s1_pair    <= {io_bus.digi_1, io_bus.digi_0};
            end
        end
    end

    // Filter next-state and commit decision; a saturated run never re-commits.
    always_comb begin
        w_match   = r_held_valid && (r_s1_pair == r_held_pair);
        w_cnt_nxt = CNT_W'(1);
        if (w_match) begin
            w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
        end
        w_commit = r_s1_valid && (w_cnt_nxt == CNT_MAX) && !(w_match && (r_cnt == CNT_MAX));
        w_value  = seg7_value(r_s1_tens, r_s1_ones);
        w_reject = r_s1_illegal || (w_value > VAL_MAX);
    end

    // Stage 2 filter state plus output stage, updated on the same edge.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_held_pair  <= '0;
            r_held_valid <= 1'b0;
            r_cnt        <= '0;
            r_hex        <= '0;
            r_hex_valid  <= 1'b0;
            r_out_valid  <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (r_s1_valid) begin
                r_held_pair  <= r_s1_pair;
                r_held_valid <= 1'b1;
                r_cnt        <= w_cnt_nxt;
            end
            r_out_valid <= w_commit && !w_reject;
            r_err       <= w_commit && w_reject;
            if (w_commit && !w_reject) begin
                r_hex       <= w_value[5:0];
                r_hex_valid <= 1'b1;
            end
        end
    end

    assign io_bus.hex       = r_hex;
    assign io_bus.hex_valid = r_hex_valid;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.err       = r_err;

endmodule

// File: tb/tb_seg7_to_hex_6bit.sv
// Scoreboard bench for seg7_to_hex_6bit: a STABLE_CNT=4 instance for the directed
// scenarios and a STABLE_CNT=1 instance that joins for the full 0..63 sweep.
module tb_seg7_to_hex_6bit;

    localparam logic [6:0] S0 = 7'b0111111;
    localparam logic [6:0] S1 = 7'b0011000;
    localparam logic [6:0] S2 = 7'b1110110;
    localparam logic [6:0] S3 = 7'b1111100;
    localparam logic [6:0] S4 = 7'b1011001;
    localparam logic [6:0] S5 = 7'b1101101;
    localparam logic [6:0] S6 = 7'b1101111;
    localparam logic [6:0] S7 = 7'b0111000;
    localparam logic [6:0] S8 = 7'b1111111;
    localparam logic [6:0] S9 = 7'b1111101;
    localparam logic [6:0] SX = 7'b0000000;
    localparam logic [6:0] SBAD = 7'b0111110;

    localparam int K_OK  = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int kind;
        int hex;
        int cyc;
    } exp_t;

    logic clock = 1'b0;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;
    exp_t q [2][$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    seg7_to_hex_6bit_if bus4 ();
    seg7_to_hex_6bit_if bus1 ();

    seg7_to_hex_6bit #(.STABLE_CNT(4)) u_dut4 (.clock(clock), .rst_n(rst_n), .io_bus(bus4));
    seg7_to_hex_6bit #(.STABLE_CNT(1)) u_dut1 (.clock(clock), .rst_n(rst_n), .io_bus(bus1));

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return S0;
            1: return S1;
            2: return S2;
            3: return S3;
            4: return S4;
            5: return S5;
            6: return S6;
            7: return S7;
            8: return S8;
            9: return S9;
            default: return SX;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One sample driven just after a rising edge; v4/v1 select which instance sees it.
    task automatic put(input logic [6:0] d1, input logic [6:0] d0, input bit v4, input bit v1);
        @(posedge clock);
        #1;
        bus4.in_valid = v4;
        bus4.digi_1   = d1;
        bus4.digi_0   = d0;
        bus1.in_valid = v1;
        bus1.digi_1   = d1;
        bus1.digi_0   = d0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            bus4.in_valid = 1'b0;
            bus1.in_valid = 1'b0;
        end
    endtask

    // A committing sample surfaces two edges after it is driven.
    task automatic push(input int id, input int kind, input int hex);
        exp_t e;
        e.kind = kind;
        e.hex  = hex;
        e.cyc  = cyc + 2;
        q[id].push_back(e);
    endtask

    task automatic sample4(input logic [6:0] d1, input logic [6:0] d0, input int kind, input int hex);
        put(d1, d0, 1'b1, 1'b0);
        if (kind != 0) push(0, kind, hex);
    endtask

    task automatic run4(input logic [6:0] d1, input logic [6:0] d0, input int n, input int kind, input int hex);
        for (int i = 1; i <= n; i++) sample4(d1, d0, (i == 4) ? kind : 0, hex);
    endtask

    task automatic mon_one(input int id, input logic ov, input logic er,
                           input logic [5:0] hx, input logic hv);
        exp_t e;
        string tag;
        tag = (id == 0) ? "s4" : "s1";
        if (ov || er) begin
            check($sformatf("%s_ov_err_exclusive", tag), int'(ov && er), 0);
            check($sformatf("%s_pulse_expected", tag), (q[id].size() > 0) ? 1 : 0, 1);
            if (q[id].size() > 0) begin
                e = q[id].pop_front();
                check($sformatf("%s_pulse_kind", tag), er ? K_ERR : K_OK, e.kind);
                check($sformatf("%s_pulse_cycle", tag), cyc, e.cyc);
                if (e.kind == K_OK && ov) begin
                    check($sformatf("%s_hex", tag), int'(hx), e.hex);
                    check($sformatf("%s_hex_valid", tag), int'(hv), 1);
                end
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clock);
            if (rst_n) begin
                mon_one(0, bus4.out_valid, bus4.err, bus4.hex, bus4.hex_valid);
                mon_one(1, bus1.out_valid, bus1.err, bus1.hex, bus1.hex_valid);
            end
        end
    endtask

    task automatic check_outs(input string tag, input int hex, input int hv);
        check({tag, "_hex"}, int'(bus4.hex), hex);
        check({tag, "_hex_valid"}, int'(bus4.hex_valid), hv);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus4.in_valid = 1'b0;
        bus4.digi_0   = '0;
        bus4.digi_1   = '0;
        bus1.in_valid = 1'b0;
        bus1.digi_0   = '0;
        bus1.digi_1   = '0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clock);
        #1;
        check("rst4_hex", int'(bus4.hex), 0);
        check("rst4_hex_valid", int'(bus4.hex_valid), 0);
        check("rst4_out_valid", int'(bus4.out_valid), 0);
        check("rst4_err", int'(bus4.err), 0);
        check("rst1_hex_valid", int'(bus1.hex_valid), 0);
        check("rst1_out_valid", int'(bus1.out_valid), 0);
        rst_n = 1'b1;

        // 42 held for 8 samples: one commit on the 4th, nothing on saturation.
        run4(S4, S2, 8, K_OK, 42);
        idle(3);
        check_outs("basic", 42, 1);
        check("basic_err_low", int'(bus4.err), 0);

        // Reset with cnt=3 wipes outputs immediately and discards progress.
        run4(S1, S3, 3, 0, 0);
        idle(2);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("midrst", 0, 0);
        check("midrst_out_valid", int'(bus4.out_valid), 0);
        check("midrst_err", int'(bus4.err), 0);
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        run4(S1, S3, 3, 0, 0);
        idle(3);
        check_outs("after_rst_3", 0, 0);
        sample4(S1, S3, K_OK, 13);
        idle(3);
        check_outs("after_rst_4", 13, 1);

        // Out of range 64 and 90: err only, hex retained.
        run4(S6, S4, 8, K_ERR, 0);
        idle(3);
        check_outs("oor64", 13, 1);
        run4(S9, S0, 4, K_ERR, 0);
        idle(3);
        check_outs("oor90", 13, 1);

        // Blank tens is zero; blank or garbage ones is illegal.
        run4(SX, S7, 4, K_OK, 7);
        run4(SX, SX, 4, K_ERR, 0);
        run4(SX, SBAD, 4, K_ERR, 0);
        idle(3);
        check_outs("blank", 7, 1);

        // A single differing sample restarts the count.
        run4(S6, S3, 3, 0, 0);
        sample4(S6, S2, 0, 0);
        run4(S6, S3, 3, 0, 0);
        idle(3);
        check_outs("glitch", 7, 1);
        sample4(S6, S3, K_OK, 63);
        idle(3);
        check_outs("glitch_commit", 63, 1);

        // Two-cycle gaps between samples delay but do not reset the count.
        for (int i = 1; i <= 4; i++) begin
            sample4(S5, S5, (i == 4) ? K_OK : 0, 55);
            if (i != 4) idle(2);
        end
        idle(3);
        check_outs("gaps", 55, 1);

        // Full sweep through both instances; tens 0 alternates blank / '0'.
        for (int v = 0; v < 64; v++) begin
            logic [6:0] d1;
            d1 = (v < 10 && (v % 2) == 0) ? SX : seg(v / 10);
            for (int k = 0; k < 4; k++) begin
                put(d1, seg(v % 10), 1'b1, 1'b1);
                if (k == 3) push(0, K_OK, v);
                if (k == 0) push(1, K_OK, v);
            end
        end
        idle(6);
        check("sweep_s4_hex", int'(bus4.hex), 63);
        check("sweep_s1_hex", int'(bus1.hex), 63);
        check("s4_pending_expected", q[0].size(), 0);
        check("s1_pending_expected", q[1].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_to_hex_6bit.md
Name: seg7_to_hex_6bit

Overview:
- Decodes a pair of 7-segment digit patterns (tens `digi_1`, ones `digi_0`) back into a 6-bit binary value, 0..63.
- Pipelined, with a stability filter: a pattern pair is committed only after it has been sampled identically for STABLE_CNT consecutive valid samples.
- Sits on the readback/self-check path of the display encoder, or behind a segment-sampling front end.
- Flags illegal patterns and out-of-range values.

Parameters:
- STABLE_CNT, 4, consecutive identical valid samples required before commit; legal range 1..255.

Ports:
- clock  in  1  clock
- rst_n  in  1  reset
- in_valid  in  1  sample strobe; `digi_0`/`digi_1` are sampled when high
- digi_0  in  7  ones-digit segment pattern
- digi_1  in  7  tens-digit segment pattern
- hex  out  6  last committed value
- hex_valid  out  1  high once any value has been committed since reset
- out_valid  out  1  one-cycle pulse: `hex` was updated this cycle
- err  out  1  one-cycle pulse: stable pattern was illegal or value > 63

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock clock.
- Reset values: `hex`=0, `hex_valid`=0, `out_valid`=0, `err`=0. All pipeline registers, counter and held pattern clear; held-pattern valid flag clears.
- Reset asserted mid-count discards all progress.

Segment encoding (bit 6..0):
- 0=0111111, 1=0011000, 2=1110110, 3=1111100, 4=1011001
- 5=1101101, 6=1101111, 7=0111000, 8=1111111, 9=1111101, blank=0000000
- Any other pattern is illegal.

Stage 1 (registered, on in_valid):
- Decode each digit to a 4-bit digit plus blank and bad flags.
- Register the digits, flags, the raw 14-bit pair, and s1_valid.
- s1_valid=0 when in_valid=0.

Validity rules:
- Blank tens digit = 0 (leading-zero suppression).
- Blank ones digit is illegal.
- Illegal pattern on either digit is illegal.

Stage 2 (filter, only when s1_valid=1; s1_valid=0 holds all state):
- Pair equals the held pair and the held pair is valid: cnt increments, saturating at STABLE_CNT.
- Otherwise: held pair <= new pair, cnt <= 1.
- Commit condition: cnt becomes exactly STABLE_CNT on this update, including the STABLE_CNT=1 reload case. Asserted at most once per run of an unchanged pattern. Saturated runs do not re-commit.

Output stage (registered, same edge as the commit update):
- value = tens*8 + tens*2 + ones, computed at 7 bits. Range check is on the 7-bit sum before truncation to 6 bits.
- Commit with illegal flag or value > 63: `err`=1 for one cycle; `hex` and `hex_valid` unchanged.
- Commit otherwise: `hex`=value, `hex_valid`=1, `out_valid`=1 for one cycle.
- `out_valid` and `err` are never high together.

Latency and gaps:
- Constant pair with in_valid high from edge 0: `out_valid`/`err` is high during the cycle after edge STABLE_CNT+1.
- Gaps in in_valid extend latency by the gap length without resetting cnt.

Decomposition:
- Shared package seg7_pkg: DIGI_0..DIGI_9 and DIGI_X (blank) 7-bit constants, and a digit-decode result struct (digit[3:0], blank, bad). The encoder and this block use the same constants.
- Sub-module seg7_digit_decode: combinational, pattern -> {digit, blank, bad}, instantiated twice.

Test Plan:
- Reset check: assert rst_n low mid-stream with cnt=3 -> all outputs 0 immediately. Apply the same pattern after release -> full STABLE_CNT samples are needed again.
- Basic decode, STABLE_CNT=4: `digi_1`=1011001, `digi_0`=1110110, in_valid high 8 cycles -> exactly one `out_valid` pulse at cycle 5, `hex`=42, `hex_valid`=1, `err`=0, no further pulses.
- Out of range: `digi_1`=1101111, `digi_0`=1011001 (64) -> `err` pulse at cycle 5, `hex` stays 42, no `out_valid`. Separately, `digi_1`=1111101 (90s) -> `err`.
- Blank handling: `digi_1`=0000000, `digi_0`=0111000 -> `hex`=7. Then `digi_0`=0000000 or 0111110 -> `err` pulse, `hex` stays 7.
- Glitch and gaps, STABLE_CNT=4: 63 for 3 samples, 1 differing sample, then 63 for 3 samples -> no commit. Then 63 for 1 more sample -> commit `hex`=63. Insert in_valid=0 gaps of 2 cycles between samples -> commit delayed by the gaps, value unchanged.
- Sweep: drive the display encoder with all 64 values (plus STABLE_CNT=1 build) and loop its outputs in -> `hex` matches every value, no `err`.
